// File: rtl/adc_seq_sampler.sv
// Multi-channel, rate-controlled sequencer for ADC082S/ADC08x8S-style SPI ADCs.
// Generates SCK from sys_clk and tags each result with the channel it was converted from.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | csn high, waiting for en and a non-empty channel mask
// S_SETUP | csn low, sck high for one half-period before the first bit
// S_SHIFT | FRAME_BITS sck cycles: address out on sdo, result in on sdi
// S_GAP   | csn high for one full sck period, result published here
// S_WAIT  | csn high until the minimum frame spacing has elapsed
module adc_seq_sampler #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 2,
    parameter int SCK_DIV    = 3,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 4,
    parameter int ADDR_POS   = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [15:0]       rate_div,
    input  logic              sdi,
    output logic              sdo,
    output logic              sck,
    output logic              csn,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        ch_out,
    output logic              data_valid,
    output logic              busy
);

    localparam int DIV_W = $clog2(2 * SCK_DIV + 1);
    localparam int K_W   = $clog2(FRAME_BITS + 1);

    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LOAD  = DIV_W'(2 * SCK_DIV - 1);
    localparam logic [K_W-1:0]   LAST_K    = K_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_WAIT
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [K_W-1:0]    bit_k;
    logic [2:0]        cur_ch;
    logic [2:0]        prev_ch;
    logic [2:0]        ptr;
    logic              prime;
    logic [DATA_W-1:0] cap;
    logic [15:0]       rate_cnt;

    logic [7:0] mask_ext;
    logic [3:0] scan_idx;
    logic [2:0] sel_ch;
    logic [2:0] next_ptr;
    logic       go;
    logic       rate_ok;
    logic       frame_end;
    logic       in_data;

    function automatic logic addr_bit(input logic [K_W-1:0] k, input logic [2:0] ch);
        int d;
        d = int'(k) - ADDR_POS;
        case (d)
            0:       return ch[2];
            1:       return ch[1];
            2:       return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    assign mask_ext = 8'(ch_mask);
    assign go       = en && (ch_mask != '0);
    assign rate_ok  = ({1'b0, rate_cnt} + 17'd1) >= {1'b0, rate_div};
    assign in_data  = (int'(bit_k) >= LEAD_BITS) && (int'(bit_k) < LEAD_BITS + DATA_W);
    assign next_ptr = (cur_ch == 3'(NUM_CH - 1)) ? 3'd0 : cur_ch + 3'd1;

    // Frame spacing satisfied: leave from the last GAP cycle or from WAIT.
    assign frame_end = (((state == S_GAP) && (div_cnt == '0)) || (state == S_WAIT)) && rate_ok;

    // Scan downward so the last hit is the lowest enabled channel at or after ptr.
    always_comb begin
        sel_ch   = ptr;
        scan_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scan_idx = {1'b0, ptr} + 4'(i);
            if (scan_idx >= 4'(NUM_CH)) begin
                scan_idx = scan_idx - 4'(NUM_CH);
            end
            if (mask_ext[scan_idx[2:0]]) begin
                sel_ch = scan_idx[2:0];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_k      <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            ptr        <= '0;
            prime      <= 1'b1;
            cap        <= '0;
            rate_cnt   <= '0;
            sdo        <= 1'b0;
            sck        <= 1'b1;
            csn        <= 1'b1;
            data_out   <= '0;
            ch_out     <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rate_cnt != 16'hFFFF) begin
                rate_cnt <= rate_cnt + 16'd1;
            end

            case (state)
                S_SETUP: begin
                    if (div_cnt == '0) begin
                        div_cnt <= HALF_LOAD;
                        bit_k   <= '0;
                        sck     <= 1'b0;
                        sdo     <= addr_bit('0, cur_ch);
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!sck) begin
                        sck     <= 1'b1;
                        div_cnt <= HALF_LOAD;
                        if (in_data) begin
                            cap <= {cap[DATA_W-2:0], sdi};
                        end
                    end else if (bit_k == LAST_K) begin
                        // The result just shifted in belongs to the previous frame's address.
                        csn        <= 1'b1;
                        div_cnt    <= GAP_LOAD;
                        state      <= S_GAP;
                        data_valid <= !prime;
                        if (!prime) begin
                            data_out <= cap;
                            ch_out   <= prev_ch;
                        end
                        prime   <= 1'b0;
                        prev_ch <= cur_ch;
                        ptr     <= next_ptr;
                    end else begin
                        bit_k   <= bit_k + K_W'(1);
                        sck     <= 1'b0;
                        div_cnt <= HALF_LOAD;
                        sdo     <= addr_bit(bit_k + K_W'(1), cur_ch);
                    end
                end
                S_GAP: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!rate_ok) begin
                        busy  <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                default: ;
            endcase

            if (((state == S_IDLE) || frame_end) && go) begin
                cur_ch   <= sel_ch;
                rate_cnt <= '0;
                csn      <= 1'b0;
                sck      <= 1'b1;
                busy     <= 1'b1;
                div_cnt  <= HALF_LOAD;
                state    <= S_SETUP;
            end else if (frame_end) begin
                busy  <= 1'b0;
                prime <= 1'b1;
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_adc_seq_sampler.sv
// Directed bench for adc_seq_sampler with a behavioural SPI ADC that returns
// the result for the channel addressed in the previous frame.
module tb_adc_seq_sampler;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  ch_mask = 2'b00;
    logic [15:0] rate_div = 16'd0;
    logic        sdi = 1'b0;
    logic        sdo;
    logic        sck;
    logic        csn;
    logic [7:0]  data_out;
    logic [2:0]  ch_out;
    logic        data_valid;
    logic        busy;

    adc_seq_sampler dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .en         (en),
        .ch_mask    (ch_mask),
        .rate_div   (rate_div),
        .sdi        (sdi),
        .sdo        (sdo),
        .sck        (sck),
        .csn        (csn),
        .data_out   (data_out),
        .ch_out     (ch_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    // ADC model: drives DOUT on sck falling edges, reads DIN on rising edges.
    logic [7:0] adc_val [0:7];
    logic [2:0] adc_addr = 3'd0;
    logic [2:0] adc_prev = 3'd0;
    int         adc_k = 0;
    logic [2:0] din_q [$];

    always @(negedge csn) begin
        adc_k    = 0;
        adc_addr = 3'd0;
    end

    always @(negedge sck) begin
        if (csn === 1'b0) begin
            if (adc_k >= 4 && adc_k < 12) sdi = adc_val[adc_prev][11 - adc_k];
            else sdi = 1'b0;
            adc_k++;
        end
    end

    always @(posedge sck) begin
        if (csn === 1'b0 && adc_k >= 3 && adc_k <= 5) adc_addr = {adc_addr[1:0], sdo};
    end

    always @(posedge csn) begin
        if (adc_k > 0) begin
            adc_prev = adc_addr;
            din_q.push_back(adc_addr);
        end
    end

    // Event monitor
    int         fall_t [$];
    int         dv_t [$];
    logic [7:0] dv_d [$];
    logic [2:0] dv_c [$];
    int         sck_pulses = 0;
    int         last_pulses = 0;
    int         last_fall = -1;
    int         sck_per = 0;
    logic       csn_q = 1'b1;
    logic       sck_q = 1'b1;

    always @(negedge sys_clk) begin
        if (csn_q === 1'b1 && csn === 1'b0) begin
            fall_t.push_back(cyc);
            sck_pulses = 0;
            last_fall  = -1;
        end
        if (csn === 1'b0 && sck_q === 1'b0 && sck === 1'b1) sck_pulses++;
        if (csn === 1'b0 && sck_q === 1'b1 && sck === 1'b0) begin
            if (last_fall >= 0) sck_per = cyc - last_fall;
            last_fall = cyc;
        end
        if (csn_q === 1'b0 && csn === 1'b1) last_pulses = sck_pulses;
        if (data_valid === 1'b1) begin
            dv_t.push_back(cyc);
            dv_d.push_back(data_out);
            dv_c.push_back(ch_out);
        end
        csn_q = csn;
        sck_q = sck;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int fb, db, nb;

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_of(input int kind);
        if (kind == 0) return fall_t.size();
        if (kind == 1) return dv_t.size();
        return din_q.size();
    endfunction

    task automatic wait_for(input string tag, input int kind, input int target, input int budget);
        int n = 0;
        while (count_of(kind) < target && n < budget) begin
            tick();
            n++;
        end
        n_assert++;
        assert (count_of(kind) >= target) else begin
            n_fail++;
            $error("FAIL %s: timeout, observed count %0d expected %0d", tag, count_of(kind), target);
        end
    endtask

    task automatic wait_bit(input string tag, input int k);
        int n = 0;
        while (!(sck_pulses >= k && sck === 1'b0) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(sck_pulses >= k && sck === 1'b0), 32'd1);
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        fb = fall_t.size();
        db = dv_t.size();
        nb = din_q.size();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_csn", 32'(csn), 32'd1);
        check("rst_sck", 32'(sck), 32'd1);
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_ch_out", 32'(ch_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single channel, free running
        adc_val[0] = 8'hA5;
        ch_mask    = 2'b01;
        rate_div   = 16'd0;
        do_reset();
        en = 1'b1;
        wait_for("t1_fall2", 0, fb + 2, 400);
        check("t1_prime_no_dv", 32'(dv_t.size() - db), 32'd0);
        check("t1_sck_pulses", 32'(last_pulses), 32'd16);
        check("t1_sck_period", 32'(sck_per), 32'd6);
        check("t1_period_a", 32'(fall_t[fb + 1] - fall_t[fb]), 32'd105);
        wait_for("t1_fall3", 0, fb + 3, 200);
        check("t1_period_b", 32'(fall_t[fb + 2] - fall_t[fb + 1]), 32'd105);
        check("t1_dv_count", 32'(dv_t.size() - db), 32'd1);
        check("t1_data", 32'(dv_d[db]), 32'hA5);
        check("t1_ch", 32'(dv_c[db]), 32'd0);

        // Two channels alternating
        adc_val[0] = 8'h12;
        adc_val[1] = 8'hE7;
        ch_mask    = 2'b11;
        do_reset();
        en = 1'b1;
        wait_for("t2_dv3", 1, db + 3, 600);
        check("t2_din0", 32'(din_q[nb]), 32'd0);
        check("t2_din1", 32'(din_q[nb + 1]), 32'd1);
        check("t2_din2", 32'(din_q[nb + 2]), 32'd0);
        check("t2_din3", 32'(din_q[nb + 3]), 32'd1);
        check("t2_d0", 32'(dv_d[db]), 32'h12);
        check("t2_c0", 32'(dv_c[db]), 32'd0);
        check("t2_d1", 32'(dv_d[db + 1]), 32'hE7);
        check("t2_c1", 32'(dv_c[db + 1]), 32'd1);
        check("t2_d2", 32'(dv_d[db + 2]), 32'h12);
        check("t2_c2", 32'(dv_c[db + 2]), 32'd0);

        // Rate limited
        adc_val[0] = 8'h3C;
        ch_mask    = 2'b01;
        rate_div   = 16'd1000;
        do_reset();
        en = 1'b1;
        wait_for("t3_fall2", 0, fb + 2, 1500);
        repeat (500) tick();
        check("t3_wait_busy", 32'(busy), 32'd0);
        check("t3_wait_csn", 32'(csn), 32'd1);
        wait_for("t3_dv2", 1, db + 2, 1500);
        check("t3_period_a", 32'(fall_t[fb + 1] - fall_t[fb]), 32'd1000);
        check("t3_period_b", 32'(fall_t[fb + 2] - fall_t[fb + 1]), 32'd1000);
        check("t3_dv_spacing", 32'(dv_t[db + 1] - dv_t[db]), 32'd1000);
        check("t3_data", 32'(dv_d[db]), 32'h3C);

        // en dropped at bit 7
        adc_val[0] = 8'h5A;
        rate_div   = 16'd0;
        do_reset();
        en = 1'b1;
        wait_for("t4_fall3", 0, fb + 3, 400);
        wait_bit("t4_reach_bit7", 7);
        en = 1'b0;
        wait_for("t4_dv2", 1, db + 2, 200);
        check("t4_full_frame", 32'(last_pulses), 32'd16);
        check("t4_data", 32'(dv_d[db + 1]), 32'h5A);
        check("t4_ch", 32'(dv_c[db + 1]), 32'd0);
        repeat (20) tick();
        check("t4_idle_csn", 32'(csn), 32'd1);
        check("t4_idle_sck", 32'(sck), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'd0);
        repeat (300) tick();
        check("t4_no_new_frame", 32'(fall_t.size() - fb), 32'd3);
        en = 1'b1;
        wait_for("t4_fall5", 0, fb + 5, 400);
        check("t4_reprime", 32'(dv_t.size() - db), 32'd2);
        wait_for("t4_dv3", 1, db + 3, 200);
        check("t4_data_after", 32'(dv_d[db + 2]), 32'h5A);

        // Reset during bit 9 of a frame with a pending result
        adc_val[0] = 8'h77;
        do_reset();
        en = 1'b1;
        wait_for("t5_fall2", 0, fb + 2, 400);
        wait_bit("t5_reach_bit9", 9);
        rst = 1'b1;
        tick();
        check("t5_csn", 32'(csn), 32'd1);
        check("t5_sck", 32'(sck), 32'd1);
        check("t5_sdo", 32'(sdo), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_dv", 32'(data_valid), 32'd0);
        rst = 1'b0;
        repeat (180) tick();
        check("t5_no_dv", 32'(dv_t.size() - db), 32'd0);
        check("t5_data_out", 32'(data_out), 32'h00);

        // Empty mask holds IDLE, then ch1 only
        ch_mask = 2'b00;
        do_reset();
        en = 1'b1;
        repeat (300) tick();
        check("t6_no_fall", 32'(fall_t.size() - fb), 32'd0);
        check("t6_csn", 32'(csn), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        ch_mask = 2'b10;
        wait_for("t6_frame", 2, nb + 1, 300);
        check("t6_addr", 32'(din_q[nb]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
